// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU requesters, the arbiter and the register-file write port.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              lsu_valid;
    logic [ADDR_W-1:0] lsu_rd;
    logic [DATA_W-1:0] lsu_data;
    logic              lsu_ready;
    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_rd_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic [15:0]       stall_cnt;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready,
        input  rf_write_enable, rf_rd_addr, rf_write_data, stall_cnt
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready,
        output rf_write_enable, rf_rd_addr, rf_write_data, stall_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter; x0 writes are swallowed, one real write per cycle.
// Define REGFILE_WB_RR_EN for round-robin contention; otherwise the LSU has fixed priority.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    regfile_wb_arbiter_if.slave  bus
);

    logic              alu_req;
    logic              lsu_req;
    logic              alu_x0;
    logic              lsu_x0;
    logic              grant_alu;
    logic              grant_lsu;
    logic              grant_any;
    logic              stalled;
    logic              last_grant;

    logic              vld_p0;
    logic [ADDR_W-1:0] rd_p0;
    logic [DATA_W-1:0] data_p0;
    logic [15:0]       stall_cnt_p0;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    always_comb begin
        alu_x0  = bus.alu_valid && (bus.alu_rd == '0);
        lsu_x0  = bus.lsu_valid && (bus.lsu_rd == '0);
        alu_req = bus.alu_valid && (bus.alu_rd != '0);
        lsu_req = bus.lsu_valid && (bus.lsu_rd != '0);
`ifdef REGFILE_WB_RR_EN
        // On contention the side that did not win last time goes next.
        grant_alu = alu_req && (!lsu_req || last_grant);
        grant_lsu = lsu_req && (!alu_req || !last_grant);
`else
        grant_lsu = lsu_req;
        grant_alu = alu_req && !lsu_req;
`endif
        grant_any = reset_n && (grant_alu || grant_lsu);
        stalled   = reset_n && ((alu_req && !grant_alu) || (lsu_req && !grant_lsu));
    end

    assign bus.alu_ready = reset_n && (alu_x0 || grant_alu);
    assign bus.lsu_ready = reset_n && (lsu_x0 || grant_lsu);

    // Stage p0: registered write port and arbitration state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p0       <= 1'b0;
            rd_p0        <= '0;
            data_p0      <= '0;
            stall_cnt_p0 <= 16'd0;
            last_grant   <= 1'b1;
        end else begin
            vld_p0     <= grant_any;
            last_grant <= grant_any ? grant_lsu : last_grant;
            if (grant_any) begin
                rd_p0   <= grant_lsu ? bus.lsu_rd   : bus.alu_rd;
                data_p0 <= grant_lsu ? bus.lsu_data : bus.alu_data;
            end
            if (stalled) begin
                stall_cnt_p0 <= sat_inc(stall_cnt_p0);
            end
        end
    end

    assign bus.rf_write_enable = vld_p0;
    assign bus.rf_rd_addr      = rd_p0;
    assign bus.rf_write_data   = data_p0;
    assign bus.stall_cnt       = stall_cnt_p0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expectations follow REGFILE_WB_RR_EN when defined.
module tb_regfile_wb_arbiter;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    logic first_alu;

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'd0;
        bus.lsu_valid = 1'b0;
        bus.lsu_rd    = 5'd0;
        bus.lsu_data  = 32'd0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h55;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd6; bus.lsu_data = 32'h66;
        @(posedge clk); #1;
        checks++; if (bus.rf_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.rf_write_enable); end
        checks++; if (bus.rf_rd_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.rf_rd_addr); end
        checks++; if (bus.rf_write_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.rf_write_data); end
        checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", bus.stall_cnt); end
        checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %b expected 0", bus.alu_ready); end
        checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL reset_lsu_ready: got %b expected 0", bus.lsu_ready); end
        reset_n = 1'b1;
        idle();
        @(posedge clk); #1;
        checks++; if (bus.rf_write_enable !== 1'b0) begin errors++; $display("FAIL reset_no_accept: got %b expected 0", bus.rf_write_enable); end
    endtask

    task automatic test_single();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready: got %b expected 1", bus.alu_ready); end
        checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL single_lsu_ready: got %b expected 0", bus.lsu_ready); end
        @(posedge clk); #1;
        idle();
        checks++; if (bus.rf_write_enable !== 1'b1) begin errors++; $display("FAIL single_we: got %b expected 1", bus.rf_write_enable); end
        checks++; if (bus.rf_rd_addr !== 5'd5) begin errors++; $display("FAIL single_addr: got %0d expected 5", bus.rf_rd_addr); end
        checks++; if (bus.rf_write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h expected deadbeef", bus.rf_write_data); end
        #1;
        checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL idle_alu_ready: got %b expected 0", bus.alu_ready); end
        @(posedge clk); #1;
        checks++; if (bus.rf_write_enable !== 1'b0) begin errors++; $display("FAIL hold_we: got %b expected 0", bus.rf_write_enable); end
        checks++; if (bus.rf_rd_addr !== 5'd5) begin errors++; $display("FAIL hold_addr: got %0d expected 5", bus.rf_rd_addr); end
        checks++; if (bus.rf_write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_data: got %h expected deadbeef", bus.rf_write_data); end
    endtask

    task automatic test_x0();
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h1234;
        #1;
        checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL x0_lsu_ready: got %b expected 1", bus.lsu_ready); end
        @(posedge clk); #1;
        idle();
        checks++; if (bus.rf_write_enable !== 1'b0) begin errors++; $display("FAIL x0_we: got %b expected 0", bus.rf_write_enable); end
        checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL x0_stall: got %0d expected 0", bus.stall_cnt); end
        checks++; if (bus.rf_rd_addr !== 5'd5) begin errors++; $display("FAIL x0_addr_hold: got %0d expected 5", bus.rf_rd_addr); end
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h44;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL mix_alu_ready: got %b expected 1", bus.alu_ready); end
        checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL mix_lsu_ready: got %b expected 1", bus.lsu_ready); end
        @(posedge clk); #1;
        idle();
        checks++; if (bus.rf_write_enable !== 1'b1) begin errors++; $display("FAIL mix_we: got %b expected 1", bus.rf_write_enable); end
        checks++; if (bus.rf_rd_addr !== 5'd4) begin errors++; $display("FAIL mix_addr: got %0d expected 4", bus.rf_rd_addr); end
        checks++; if (bus.rf_write_data !== 32'h44) begin errors++; $display("FAIL mix_data: got %h expected 44", bus.rf_write_data); end
        checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL mix_stall: got %0d expected 0", bus.stall_cnt); end
    endtask

    task automatic test_contention();
        do_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h33;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h77;
`ifdef REGFILE_WB_RR_EN
        for (int i = 0; i < 4; i++) begin
            logic exp_alu;
            exp_alu = ((i % 2) == 0);
            #1;
            checks++; if (bus.alu_ready !== exp_alu) begin errors++; $display("FAIL rr_alu_ready[%0d]: got %b expected %b", i, bus.alu_ready, exp_alu); end
            checks++; if (bus.lsu_ready !== !exp_alu) begin errors++; $display("FAIL rr_lsu_ready[%0d]: got %b expected %b", i, bus.lsu_ready, !exp_alu); end
            @(posedge clk); #1;
            checks++; if (bus.rf_rd_addr !== (exp_alu ? 5'd3 : 5'd7)) begin errors++; $display("FAIL rr_addr[%0d]: got %0d expected %0d", i, bus.rf_rd_addr, exp_alu ? 3 : 7); end
            checks++; if (bus.stall_cnt !== 16'(i + 1)) begin errors++; $display("FAIL rr_stall[%0d]: got %0d expected %0d", i, bus.stall_cnt, i + 1); end
        end
`else
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL fp_lsu_ready[%0d]: got %b expected 1", i, bus.lsu_ready); end
            checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL fp_alu_ready[%0d]: got %b expected 0", i, bus.alu_ready); end
            @(posedge clk); #1;
            checks++; if (bus.rf_rd_addr !== 5'd7) begin errors++; $display("FAIL fp_addr[%0d]: got %0d expected 7", i, bus.rf_rd_addr); end
            checks++; if (bus.stall_cnt !== 16'(i + 1)) begin errors++; $display("FAIL fp_stall[%0d]: got %0d expected %0d", i, bus.stall_cnt, i + 1); end
        end
        bus.lsu_valid = 1'b0;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL fp_alu_late: got %b expected 1", bus.alu_ready); end
        @(posedge clk); #1;
        checks++; if (bus.rf_rd_addr !== 5'd3 || bus.rf_write_data !== 32'h33) begin errors++; $display("FAIL fp_alu_write: got %0d/%h expected 3/33", bus.rf_rd_addr, bus.rf_write_data); end
        checks++; if (bus.stall_cnt !== 16'd2) begin errors++; $display("FAIL fp_stall_end: got %0d expected 2", bus.stall_cnt); end
`endif
        idle();
    endtask

    task automatic test_same_rd();
        logic [31:0] d1, d2;
        d1 = first_alu ? 32'hA : 32'hB;
        d2 = first_alu ? 32'hB : 32'hA;
        do_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'hA;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'hB;
        #1;
        checks++; if (bus.alu_ready !== first_alu) begin errors++; $display("FAIL same_ready1: got %b expected %b", bus.alu_ready, first_alu); end
        @(posedge clk); #1;
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_rd_addr !== 5'd9 || bus.rf_write_data !== d1) begin
            errors++; $display("FAIL same_write1: got %b/%0d/%h expected 1/9/%h", bus.rf_write_enable, bus.rf_rd_addr, bus.rf_write_data, d1);
        end
        if (first_alu) bus.alu_valid = 1'b0; else bus.lsu_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_rd_addr !== 5'd9 || bus.rf_write_data !== d2) begin
            errors++; $display("FAIL same_write2: got %b/%0d/%h expected 1/9/%h", bus.rf_write_enable, bus.rf_rd_addr, bus.rf_write_data, d2);
        end
        checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL same_stall: got %0d expected 1", bus.stall_cnt); end
        idle();
    endtask

    task automatic test_reset_mid();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h33;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h77;
        #1;
        checks++; if (bus.alu_ready !== first_alu) begin errors++; $display("FAIL mid_ready: got %b expected %b", bus.alu_ready, first_alu); end
        @(posedge clk); #1;
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.stall_cnt !== 16'd2) begin errors++; $display("FAIL mid_accept: got %b/%0d expected 1/2", bus.rf_write_enable, bus.stall_cnt); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.alu_ready !== 1'b0 || bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_rst: got %b/%b expected 0/0", bus.alu_ready, bus.lsu_ready); end
        @(posedge clk); #1;
        checks++; if (bus.rf_write_enable !== 1'b0) begin errors++; $display("FAIL mid_we: got %b expected 0", bus.rf_write_enable); end
        checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL mid_stall: got %0d expected 0", bus.stall_cnt); end
        checks++; if (bus.rf_rd_addr !== 5'd0) begin errors++; $display("FAIL mid_addr: got %0d expected 0", bus.rf_rd_addr); end
        reset_n = 1'b1;
        idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h22;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL resume_ready: got %b expected 1", bus.alu_ready); end
        @(posedge clk); #1;
        idle();
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_rd_addr !== 5'd2 || bus.rf_write_data !== 32'h22) begin
            errors++; $display("FAIL resume_write: got %b/%0d/%h expected 1/2/22", bus.rf_write_enable, bus.rf_rd_addr, bus.rf_write_data);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
`ifdef REGFILE_WB_RR_EN
        first_alu = 1'b1;
`else
        first_alu = 1'b0;
`endif
        reset_n = 1'b0;
        idle();
        test_reset();
        test_single();
        test_x0();
        test_contention();
        test_same_rd();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the write-data width.
REQ-002 SHALL have parameter ADDR_W, default 5, the register-address width.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port alu_valid  input  1  ALU writeback request.
REQ-006 SHALL have port alu_rd  input  ADDR_W  ALU destination register.
REQ-007 SHALL have port alu_data  input  DATA_W  ALU result.
REQ-008 SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-009 SHALL have port lsu_valid  input  1  load-unit writeback request.
REQ-010 SHALL have port lsu_rd  input  ADDR_W  load destination register.
REQ-011 SHALL have port lsu_data  input  DATA_W  load data.
REQ-012 SHALL have port lsu_ready  output  1  LSU request accepted this cycle.
REQ-013 SHALL have port rf_write_enable  output  1  register-file write strobe.
REQ-014 SHALL have port rf_rd_addr  output  ADDR_W  register-file write address.
REQ-015 SHALL have port rf_write_data  output  DATA_W  register-file write data.
REQ-016 SHALL have port stall_cnt  output  16  cycles a valid non-x0 request waited.

Function
REQ-017 SHALL accept a request (transfer) in any cycle where its valid and ready are both high; ready is combinational from valid and internal state.
REQ-018 SHALL drive each ready low whenever its valid is low.
REQ-019 SHALL accept any request with rd == 0 immediately. It SHALL produce no write and SHALL NOT affect the arbitration state.
REQ-020 SHALL accept exactly one non-x0 request per cycle. It SHALL accept it unconditionally when it is the only one valid.
REQ-021 SHALL register the accepted non-x0 request; in the next cycle rf_write_enable = 1 with that rd/data (latency 1 cycle).
REQ-022 SHALL hold rf_write_enable at 0 in any cycle following one with no non-x0 transfer. In that case rf_rd_addr and rf_write_data SHALL hold their previous values.
REQ-023 SHALL resolve contention between two valid non-x0 requests with the policy in REQ-031/REQ-032; the loser sees ready = 0 and must hold valid, rd and data stable.
REQ-024 SHALL resolve requests to the same rd in the same cycle like any contention; both writes SHALL occur, in grant order, on consecutive cycles.
REQ-025 SHALL increment stall_cnt by 1 for each requester with valid = 1, rd != 0 and ready = 0 in a cycle, i.e. by at most 1 per cycle. stall_cnt SHALL saturate at 16'hFFFF.
REQ-026 SHALL keep a 1-bit last_grant register (0 = ALU, 1 = LSU), updated only on a non-x0 transfer.

Reset
REQ-027 SHALL, while reset_n = 0 at a rising edge, set rf_write_enable = 0, rf_rd_addr = 0, rf_write_data = 0, stall_cnt = 0 and last_grant = 1.
REQ-028 SHALL force alu_ready = 0 and lsu_ready = 0 while reset_n = 0; requests presented during reset are not accepted.
REQ-029 SHALL, on reset asserted mid-stream, drop any registered write: rf_write_enable = 0 on the cycle after the reset edge.
REQ-030 SHALL resume arbitration on the first rising edge with reset_n = 1.

Configuration
REQ-031 SHALL, with macro REGFILE_WB_RR_EN defined, arbitrate contention round-robin: grant the requester not equal to last_grant.
REQ-032 SHALL, with REGFILE_WB_RR_EN undefined, use fixed priority: LSU always wins contention, and last_grant is unused apart from its reset.

Verification
REQ-033 SHALL test a single request: alu_valid = 1, alu_rd = 5, alu_data = 0xDEADBEEF -> alu_ready = 1 that cycle; next cycle rf_write_enable = 1, rf_rd_addr = 5, rf_write_data = 0xDEADBEEF.
REQ-034 SHALL test an x0 drop: lsu_valid = 1, lsu_rd = 0, lsu_data = 0x1234 -> lsu_ready = 1; next cycle rf_write_enable = 0 and stall_cnt unchanged.
REQ-035 SHALL test contention with RR enabled, both valid for 4 cycles, rd 3 (ALU) / 7 (LSU), starting from reset -> grants ALU, LSU, ALU, LSU.
REQ-036 SHALL test contention with RR disabled, both valid and held -> LSU granted first; ALU granted only after lsu_valid drops; stall_cnt = 1 after a single contended cycle.
REQ-037 SHALL test same-rd contention: both rd = 9, ALU data 0xA, LSU data 0xB, RR from reset -> writes 0xA then 0xB to register 9 on consecutive cycles.
REQ-038 SHALL test reset mid-stream: reset_n = 0 in the cycle a transfer is accepted -> rf_write_enable = 0 next cycle, stall_cnt = 0, both ready = 0.
